// File: rtl/stepper_indexer.sv
// Stepper-motor indexer: four-coil phase sequencer driven by synchronised STEP/DIR
// pulses or by an internal absolute-position move engine with a programmable step rate.
module stepper_indexer #(
    parameter int POS_W       = 32,
    parameter int DIV_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             ext_ctrl,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             move_start,
    input  logic [POS_W-1:0] move_target,
    input  logic [DIV_W-1:0] move_period,
    output logic             move_busy,
    output logic             move_done,
    output logic             step_pulse,
    output logic [POS_W-1:0] position,
    output logic [3:0]       coils
);

    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t state;
    state_t state_nx;

    logic [SYNC_STAGES-1:0] step_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic                   step_d;
    logic                   edge_q;
    logic                   edge_dir_q;

    logic [POS_W-1:0] tgt_q;
    logic [DIV_W-1:0] per_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nx;
    logic [2:0]       idx;

    logic at_target;
    logic div_hit;
    logic run_active;
    logic accept_start;
    logic int_step;
    logic ext_step;
    logic any_step;
    logic step_fwd;
    logic done_set;
    logic [2:0] idx_sz;

    function automatic logic [3:0] coil_lut(input logic [2:0] i);
        case (i)
            3'd0:    coil_lut = 4'b1000;
            3'd1:    coil_lut = 4'b1100;
            3'd2:    coil_lut = 4'b0100;
            3'd3:    coil_lut = 4'b0110;
            3'd4:    coil_lut = 4'b0010;
            3'd5:    coil_lut = 4'b0011;
            3'd6:    coil_lut = 4'b0001;
            default: coil_lut = 4'b1001;
        endcase
    endfunction

    // The edge is registered together with its direction, giving the E+SYNC_STAGES+1 latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sync  <= '0;
            dir_sync   <= '0;
            step_d     <= 1'b0;
            edge_q     <= 1'b0;
            edge_dir_q <= 1'b0;
        end else begin
            step_sync  <= {step_sync[SYNC_STAGES-2:0], step_in};
            dir_sync   <= {dir_sync[SYNC_STAGES-2:0], dir_in};
            step_d     <= step_sync[SYNC_STAGES-1];
            edge_q     <= step_sync[SYNC_STAGES-1] & ~step_d;
            edge_dir_q <= dir_sync[SYNC_STAGES-1];
        end
    end

    assign ext_step  = edge_q & ext_ctrl & ena;
    assign at_target = (position == tgt_q);
    assign div_hit   = (div_q == (per_q - DIV_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Abort via ext_ctrl takes priority over the ena hold; target check precedes stepping.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (move_start && !ext_ctrl && ena) state_nx = S_RUN;
            S_RUN: begin
                if (ext_ctrl)              state_nx = S_IDLE;
                else if (ena && at_target) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        move_busy    = (state == S_RUN);
        run_active   = (state == S_RUN) && !ext_ctrl && ena;
        accept_start = (state == S_IDLE) && move_start && !ext_ctrl && ena;
        done_set     = run_active && at_target;
        int_step     = run_active && !at_target && div_hit;
        div_nx       = div_q;
        if (accept_start)                  div_nx = '0;
        else if (run_active && !at_target) div_nx = div_hit ? '0 : div_q + DIV_ONE;
    end

    assign any_step = ext_step | int_step;
    assign step_fwd = ext_step ? edge_dir_q : ($signed(tgt_q) > $signed(position));

    // Full-step wants odd idx, wave wants even; a mis-parity step moves by one to realign.
    always_comb begin
        idx_sz = 3'd1;
        case (mode)
            2'b10:   idx_sz = 3'd1;
            2'b01:   idx_sz = idx[0] ? 3'd1 : 3'd2;
            default: idx_sz = idx[0] ? 3'd2 : 3'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q      <= '0;
            per_q      <= DIV_ONE;
            div_q      <= '0;
            move_done  <= 1'b0;
            step_pulse <= 1'b0;
            position   <= '0;
            idx        <= 3'd1;
            coils      <= 4'b0000;
        end else begin
            if (accept_start) begin
                tgt_q <= move_target;
                per_q <= (move_period == '0) ? DIV_ONE : move_period;
            end
            div_q      <= div_nx;
            move_done  <= done_set;
            step_pulse <= any_step;
            if (any_step) begin
                position <= step_fwd ? position + POS_ONE : position - POS_ONE;
                idx      <= step_fwd ? idx + idx_sz : idx - idx_sz;
            end
            coils <= ena ? coil_lut(idx) : 4'b0000;
        end
    end

endmodule
